// File: rtl/output_layer_collector_pkg.sv
// ---------------------------------------------------------------------------
// output_layer_collector_pkg
//   Shared types and helpers for the output-layer collector and the
//   hidden-layer stages that reuse the same clamping rule.
//   - collector_state_t : two-state collector FSM encoding (COLLECT, FULL)
//   - relu_clamp        : width-generic ReLU; caller zero-extends the value to
//                         CLAMP_MAX_W bits and truncates the result back to
//                         its own neuron width.
// ---------------------------------------------------------------------------
package output_layer_collector_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } collector_state_t;

    localparam int CLAMP_MAX_W = 64;

    // Returns zero when clamping is enabled and the sign bit at position
    // width-1 is set; otherwise the value passes through bit-exact.
    function automatic logic [CLAMP_MAX_W-1:0] relu_clamp(
        input logic [CLAMP_MAX_W-1:0] value,
        input int                     width,
        input bit                     enable
    );
        relu_clamp = value;
        if (enable && value[width-1])
            relu_clamp = '0;
    endfunction

endpackage

// File: rtl/output_layer_collector.sv
// ---------------------------------------------------------------------------
// output_layer_collector
//   Gathers the serial output-layer neuron stream into one packed probability
//   vector per image and hands it to the label-finding stage over a
//   valid/ready handshake. Counts completed frames.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset (priority over flush)
//   flush          drop the partial/held frame, return to COLLECT
//   neuron_value   one signed neuron result (n bits)
//   neuron_valid   neuron_value valid this cycle
//   neuron_ready   collector accepts neuron_value this cycle (COLLECT)
//   numbers        packed frame, slot i at [n*i +: n]
//   numbers_valid  numbers holds a complete frame (FULL)
//   numbers_ready  downstream takes the frame this cycle
//   frame_count    frames handed off since reset, wraps
// ---------------------------------------------------------------------------
module output_layer_collector
    import output_layer_collector_pkg::*;
#(
    parameter int n                    = 8,
    parameter int size_of_output_layer = 10,
    parameter int clog2_size           = 4,
    parameter int RELU                 = 1,
    parameter int frame_cnt_w          = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [n-1:0]                      neuron_value,
    input  logic                              neuron_valid,
    output logic                              neuron_ready,
    output logic [n*size_of_output_layer-1:0] numbers,
    output logic                              numbers_valid,
    input  logic                              numbers_ready,
    output logic [frame_cnt_w-1:0]            frame_count
);

    localparam logic [clog2_size-1:0] LAST_IDX = clog2_size'(size_of_output_layer - 1);

    collector_state_t                  r_state;
    logic [clog2_size-1:0]             r_idx;
    logic [n*size_of_output_layer-1:0] r_numbers;
    logic                              r_neuron_ready;
    logic                              r_numbers_valid;
    logic [frame_cnt_w-1:0]            r_frame_count;
    logic [n-1:0]                      w_clamped;

    assign w_clamped = n'(relu_clamp(CLAMP_MAX_W'(neuron_value), n, RELU != 0));

    // Single FSM block; the handshake outputs are registered copies of the
    // state decode so nothing on the outputs depends combinationally on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= COLLECT;
            r_idx           <= '0;
            r_numbers       <= '0;
            r_neuron_ready  <= 1'b1;
            r_numbers_valid <= 1'b0;
            r_frame_count   <= '0;
        end else if (flush) begin
            // Drops any input presented this cycle and any held frame,
            // including one that would otherwise handshake now.
            r_state         <= COLLECT;
            r_idx           <= '0;
            r_numbers       <= '0;
            r_neuron_ready  <= 1'b1;
            r_numbers_valid <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (neuron_valid) begin
                        for (int i = 0; i < size_of_output_layer; i++) begin
                            if (r_idx == clog2_size'(i))
                                r_numbers[n*i +: n] <= w_clamped;
                        end
                        if (r_idx == LAST_IDX) begin
                            r_idx           <= '0;
                            r_state         <= FULL;
                            r_neuron_ready  <= 1'b0;
                            r_numbers_valid <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    // No bypass: the next frame starts one cycle after handoff.
                    if (numbers_ready) begin
                        r_state         <= COLLECT;
                        r_numbers       <= '0;
                        r_neuron_ready  <= 1'b1;
                        r_numbers_valid <= 1'b0;
                        r_frame_count   <= r_frame_count + 1'b1;
                    end
                end
                default: begin
                    r_state         <= COLLECT;
                    r_idx           <= '0;
                    r_numbers       <= '0;
                    r_neuron_ready  <= 1'b1;
                    r_numbers_valid <= 1'b0;
                end
            endcase
        end
    end

    assign neuron_ready  = r_neuron_ready;
    assign numbers       = r_numbers;
    assign numbers_valid = r_numbers_valid;
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_output_layer_collector.sv
module tb_output_layer_collector;

  localparam int N  = 8;
  localparam int SZ = 10;
  localparam int FW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, flush, neuron_valid, numbers_ready;
  logic [N-1:0]  neuron_value;

  // dut1: RELU=1, dut0: RELU=0, both driven by the same stimulus
  logic          ready1, valid1, ready0, valid0;
  logic [N*SZ-1:0] numbers1, numbers0;
  logic [FW-1:0] count1, count0;

  output_layer_collector #(.n(N), .size_of_output_layer(SZ), .clog2_size(4),
                           .RELU(1), .frame_cnt_w(FW)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .neuron_value(neuron_value), .neuron_valid(neuron_valid), .neuron_ready(ready1),
    .numbers(numbers1), .numbers_valid(valid1), .numbers_ready(numbers_ready),
    .frame_count(count1));

  output_layer_collector #(.n(N), .size_of_output_layer(SZ), .clog2_size(4),
                           .RELU(0), .frame_cnt_w(FW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .neuron_value(neuron_value), .neuron_valid(neuron_valid), .neuron_ready(ready0),
    .numbers(numbers0), .numbers_valid(valid0), .numbers_ready(numbers_ready),
    .frame_count(count0));

  int vectors = 0;
  int errors  = 0;

  // reference model state
  logic [N-1:0] exp_vals [SZ];
  int           exp_cnt;

  // Expected packed vector: first `upto` slots hold the model values,
  // the rest read zero; negative values become zero when relu is set.
  function automatic logic [N*SZ-1:0] model_frame(input bit relu, input int upto);
    logic [N*SZ-1:0] r;
    logic [N-1:0]    v;
    r = '0;
    for (int s = 0; s < SZ; s++) begin
      v = (s < upto) ? exp_vals[s] : '0;
      if (relu && $signed(v) < 0) v = '0;
      r[N*s +: N] = v;
    end
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_range(input int lo, input int hi, input int gap_pct);
    for (int i = lo; i < hi; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        neuron_valid = 1'b0;
        neuron_value = 8'($urandom);
        tick();
      end
      neuron_valid = 1'b1;
      neuron_value = exp_vals[i];
      tick();
    end
    neuron_valid = 1'b0;
  endtask

  task automatic rand_vals;
    for (int i = 0; i < SZ; i++) exp_vals[i] = 8'($urandom);
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; neuron_valid = 1'b0; numbers_ready = 1'b0;
    neuron_value = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    exp_cnt = 0;
    vectors++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0 || numbers1 !== '0 || count1 !== '0) begin
      errors++;
      $display("FAIL reset: ready=%b valid=%b numbers=%h count=%0d, need 1 0 0 0",
               ready1, valid1, numbers1, count1);
    end
  endtask

  task automatic test_basic;
    logic [N*SZ-1:0] exp;
    for (int i = 0; i < SZ; i++) exp_vals[i] = 8'(10 * (i + 1));
    numbers_ready = 1'b1;
    feed_range(0, SZ - 1, 0);
    vectors++;
    if (valid1 !== 1'b0 || numbers1 !== model_frame(1, SZ - 1)) begin
      errors++;
      $display("FAIL basic_partial: valid=%b numbers=%h, need 0 %h",
               valid1, numbers1, model_frame(1, SZ - 1));
    end
    feed_range(SZ - 1, SZ, 0);
    exp = model_frame(1, SZ);
    vectors++;
    if (valid1 !== 1'b1 || ready1 !== 1'b0 || numbers1 !== exp ||
        numbers1[7:0] !== 8'd10 || numbers1[79:72] !== 8'd100) begin
      errors++;
      $display("FAIL basic_full: valid=%b ready=%b numbers=%h, need 1 0 %h",
               valid1, ready1, numbers1, exp);
    end
    tick();
    exp_cnt++;
    vectors++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0 || numbers1 !== '0 || count1 !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL basic_handoff: ready=%b valid=%b numbers=%h count=%0d, need 1 0 0 %0d",
               ready1, valid1, numbers1, count1, exp_cnt);
    end
    numbers_ready = 1'b0;
  endtask

  task automatic test_relu;
    exp_vals[0] = 8'hF0; exp_vals[1] = 8'h7F; exp_vals[2] = 8'h80; exp_vals[3] = 8'h01;
    for (int i = 4; i < SZ; i++) exp_vals[i] = 8'h00;
    feed_range(0, SZ, 0);
    vectors++;
    if (numbers1 !== model_frame(1, SZ) || numbers1[7:0] !== 8'h00 || numbers1[23:16] !== 8'h00) begin
      errors++;
      $display("FAIL relu_on: numbers=%h, need %h", numbers1, model_frame(1, SZ));
    end
    vectors++;
    if (numbers0 !== model_frame(0, SZ) || numbers0[7:0] !== 8'hF0 || numbers0[23:16] !== 8'h80) begin
      errors++;
      $display("FAIL relu_off: numbers=%h, need %h", numbers0, model_frame(0, SZ));
    end
    numbers_ready = 1'b1;
    tick();
    numbers_ready = 1'b0;
    exp_cnt++;
    vectors++;
    if (count1 !== 16'(exp_cnt) || count0 !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL relu_count: count1=%0d count0=%0d, need %0d", count1, count0, exp_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [N*SZ-1:0] exp;
    rand_vals();
    feed_range(0, SZ, 0);
    exp = model_frame(1, SZ);
    neuron_valid = 1'b1;
    neuron_value = 8'h55;
    for (int c = 0; c < 5; c++) begin
      tick();
      vectors++;
      if (numbers1 !== exp || ready1 !== 1'b0 || valid1 !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: numbers=%h ready=%b valid=%b, need %h 0 1",
                 c, numbers1, ready1, valid1, exp);
      end
    end
    numbers_ready = 1'b1;
    tick();
    numbers_ready = 1'b0;
    exp_cnt++;
    vectors++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0 || count1 !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL backpressure_release: ready=%b valid=%b count=%0d, need 1 0 %0d",
               ready1, valid1, count1, exp_cnt);
    end
    tick();  // 0x55 still presented, now accepted into slot0
    neuron_valid = 1'b0;
    vectors++;
    if (numbers1[7:0] !== 8'h55 || numbers0[7:0] !== 8'h55 || numbers1[N*SZ-1:8] !== '0) begin
      errors++;
      $display("FAIL backpressure_slot0: numbers=%h, need slot0=55 rest 0", numbers1);
    end
    exp_vals[0] = 8'h55;
    for (int i = 1; i < SZ; i++) exp_vals[i] = 8'($urandom);
    feed_range(1, SZ, 0);
    vectors++;
    if (valid1 !== 1'b1 || numbers1 !== model_frame(1, SZ) || numbers0 !== model_frame(0, SZ)) begin
      errors++;
      $display("FAIL backpressure_next: numbers1=%h numbers0=%h, need %h %h",
               numbers1, numbers0, model_frame(1, SZ), model_frame(0, SZ));
    end
    numbers_ready = 1'b1;
    tick();
    numbers_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_gapped;
    int waitc;
    for (int f = 0; f < 4; f++) begin
      rand_vals();
      feed_range(0, SZ, 50);
      vectors++;
      if (valid1 !== 1'b1 || numbers1 !== model_frame(1, SZ) || numbers0 !== model_frame(0, SZ)) begin
        errors++;
        $display("FAIL gapped_frame[%0d]: numbers1=%h numbers0=%h, need %h %h",
                 f, numbers1, numbers0, model_frame(1, SZ), model_frame(0, SZ));
      end
      waitc = $urandom_range(3);
      for (int w = 0; w < waitc; w++) tick();
      numbers_ready = 1'b1;
      tick();
      numbers_ready = 1'b0;
      exp_cnt++;
      vectors++;
      if (count1 !== 16'(exp_cnt) || count0 !== 16'(exp_cnt) || ready1 !== 1'b1) begin
        errors++;
        $display("FAIL gapped_count[%0d]: count=%0d ready=%b, need %0d 1",
                 f, count1, ready1, exp_cnt);
      end
    end
  endtask

  task automatic test_flush;
    rand_vals();
    feed_range(0, 4, 0);
    flush = 1'b1;
    neuron_valid = 1'b1;
    neuron_value = 8'h33;
    tick();
    flush = 1'b0;
    neuron_valid = 1'b0;
    vectors++;
    if (numbers1 !== '0 || ready1 !== 1'b1 || valid1 !== 1'b0 || count1 !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL flush_collect: numbers=%h ready=%b valid=%b count=%0d, need 0 1 0 %0d",
               numbers1, ready1, valid1, count1, exp_cnt);
    end
    rand_vals();
    feed_range(0, SZ, 0);
    vectors++;
    if (valid1 !== 1'b1 || numbers1 !== model_frame(1, SZ) || numbers0 !== model_frame(0, SZ)) begin
      errors++;
      $display("FAIL flush_clean_frame: numbers=%h, need %h", numbers1, model_frame(1, SZ));
    end
    flush = 1'b1;
    numbers_ready = 1'b1;
    tick();
    flush = 1'b0;
    numbers_ready = 1'b0;
    vectors++;
    if (count1 !== 16'(exp_cnt) || valid1 !== 1'b0 || ready1 !== 1'b1 || numbers1 !== '0) begin
      errors++;
      $display("FAIL flush_full: count=%0d valid=%b ready=%b numbers=%h, need %0d 0 1 0",
               count1, valid1, ready1, numbers1, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    rand_vals();
    feed_range(0, 7, 0);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    exp_cnt = 0;
    vectors++;
    if (ready1 !== 1'b1 || valid1 !== 1'b0 || numbers1 !== '0 || count1 !== '0 || count0 !== '0) begin
      errors++;
      $display("FAIL reset_mid: ready=%b valid=%b numbers=%h count=%0d, need 1 0 0 0",
               ready1, valid1, numbers1, count1);
    end
    rand_vals();
    feed_range(0, 1, 0);
    vectors++;
    if (numbers1 !== model_frame(1, 1)) begin
      errors++;
      $display("FAIL reset_mid_slot0: numbers=%h, need %h", numbers1, model_frame(1, 1));
    end
    feed_range(1, SZ, 0);
    numbers_ready = 1'b1;
    vectors++;
    if (valid1 !== 1'b1 || numbers1 !== model_frame(1, SZ)) begin
      errors++;
      $display("FAIL reset_mid_frame: numbers=%h, need %h", numbers1, model_frame(1, SZ));
    end
    tick();
    numbers_ready = 1'b0;
    exp_cnt++;
    vectors++;
    if (count1 !== 16'(exp_cnt)) begin
      errors++;
      $display("FAIL reset_mid_count: count=%0d, need %0d", count1, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_backpressure();
    test_gapped();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/output_layer_collector.md
Name: output_layer_collector

Overview:
- Sits directly upstream of the label-finding stage.
- Takes output-layer neuron results as a serial stream, one value per transfer, from the time-multiplexed output neuron.
- Optionally applies ReLU clamping to each value and packs size_of_output_layer values into the flat probability vector that the label stage consumes.
- Presents the packed vector with a valid/ready handshake and counts completed frames (one frame = one image).

Parameters:
- n, 8, bit width of one neuron output (two's complement).
- size_of_output_layer, 10, number of neuron outputs per frame.
- clog2_size, 4, width of the slot index; must be at least clog2(size_of_output_layer).
- RELU, 1, when 1, negative inputs are stored as zero; when 0, stored unchanged.
- frame_cnt_w, 16, width of the frame counter.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  discards the partial frame and returns to COLLECT; frame count is kept.
- neuron_value  input  n  one output-layer result, signed.
- neuron_valid  input  1  neuron_value is valid this cycle.
- neuron_ready  output  1  collector accepts neuron_value this cycle.
- numbers  output  n*size_of_output_layer  packed frame; slot i occupies bits [n*i +: n].
- numbers_valid  output  1  numbers holds a complete frame.
- numbers_ready  input  1  downstream consumes the frame this cycle.
- frame_count  output  frame_cnt_w  number of frames handed off since reset; wraps to 0.

Behaviour:
- Reset (synchronous, active-high): state=COLLECT, slot index=0, numbers=0, numbers_valid=0, frame_count=0. neuron_ready=1 from the first cycle after reset deasserts.
- Two states: COLLECT and FULL.
- COLLECT:
  - neuron_ready=1 and numbers_valid=0.
  - Input accepted when neuron_valid=1.
  - Accepted value, after clamping, is written to slot[idx]; idx then increments.
  - Accepting at idx=size_of_output_layer-1 writes the last slot, resets idx to 0 and moves to FULL on the same edge.
  - numbers_valid goes to 1 in the cycle after the last accept. Latency from last accept to valid is 1 cycle.
- FULL:
  - numbers_valid=1 and neuron_ready=0 (no bypass); numbers is held stable.
  - When numbers_ready=1: the frame transfers, frame_count increments (wraps modulo 2^frame_cnt_w), state returns to COLLECT, and numbers clears to 0.
  - neuron_ready=1 again the next cycle.
  - Minimum frame period is size_of_output_layer+1 cycles.
- Clamping:
  - If RELU=1 and neuron_value[n-1]=1, the stored value is 0.
  - Otherwise the stored value is bit-exact. No width change.
- Slots not yet written in a partial frame read 0. numbers is observable in COLLECT but is only meaningful when numbers_valid=1.
- flush:
  - In COLLECT: idx→0 and numbers→0. An input presented in the same cycle is dropped, so flush wins.
  - In FULL: the frame is discarded without incrementing frame_count and the block returns to COLLECT. If numbers_ready is also 1 in that cycle, flush still wins and there is no handshake.
- rst has priority over flush. Reset mid-frame discards everything.
- numbers_ready is ignored in COLLECT. neuron_valid is ignored in FULL, and the upstream source must hold its value until neuron_ready=1.
- Outputs are driven directly from registers; state decodes to neuron_ready and numbers_valid. No combinational path from input to output.

Decomposition:
- Shared package: state encoding (COLLECT, FULL) and a relu_clamp function parameterised on n, reused by hidden-layer stages.
- No sub-module. The whole block is a single module containing an index counter, a slot register array and a two-state FSM.

Test Plan:
- Basic frame (RELU=1, n=8, size=10): feed 10,20,…,100 back-to-back with numbers_ready=1 → numbers_valid rises 1 cycle after the 10th accept; numbers[7:0]=10, numbers[79:72]=100; frame_count=1 after the handshake; neuron_ready=0 for exactly one cycle.
- ReLU: feed values 0xF0, 0x7F, 0x80, 0x01 and then 6×0x00 → slots read 0x00, 0x7F, 0x00, 0x01, then zeros. Same stimulus with RELU=0 → slot0=0xF0, slot2=0x80.
- Backpressure: complete a frame with numbers_ready=0 for 5 cycles while neuron_valid=1 and value 0x55 → numbers is stable, neuron_ready=0, no slot overwritten; after numbers_ready pulses, the next frame's slot0=0x55.
- Gapped input: deassert neuron_valid randomly on 50% of cycles → frame contents are in order; frame_count increments once per frame.
- Flush: flush after 4 accepts → idx resets, numbers=0, and the next 10 inputs form a clean frame. Flush in FULL together with numbers_ready=1 → frame_count unchanged.
- Reset mid-frame after 7 accepts → all outputs at reset values next cycle; frame_count=0; a new frame starts at slot0.
